id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
Registered, parametrised MIPS instruction-decode stage. It decodes the integer ALU subset and resolves operands with EX/MEM forwarding. It detects load-use hazards and presents the result through a valid/ready ID/EX pipeline register with flush support. It sits between the IF/ID register and the EX stage and drives the register-file read ports combinationally.

Parameters:
DATA_W, 32, datapath width (>=32); immediates sign/zero-extended to DATA_W
FWD_EN, 1, 1 = forward from EX/MEM; 0 = every RAW on a nonzero reg in EX/MEM stalls
PC_W, 32, program-counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  IF/ID holds a valid instruction
in_ready  out  1  stage accepts instruction this cycle
pc_i  in  PC_W  instruction address
inst_i  in  32  instruction word
reg1_addr_o / reg2_addr_o  out  5  regfile read addresses, combinational = inst_i[25:21] / inst_i[20:16]
reg1_read_o / reg2_read_o  out  1  port used by decoded instruction (combinational)
reg1_data_i / reg2_data_i  in  DATA_W  regfile read data, same cycle
ex_wreg_i, ex_wd_i[4:0], ex_wdata_i[DATA_W], ex_is_load_i  in  EX-stage writeback info
mem_wreg_i, mem_wd_i[4:0], mem_wdata_i[DATA_W]  in  MEM-stage writeback info
flush_i  in  1  kill held and incoming instruction
out_valid  out  1  ID/EX register valid
out_ready  in  1  EX accepts
alusel_o  out  3  0 nop, 1 logic, 2 shift, 3 arith
aluop_o  out  8  R-type {2'b00,funct}; I-type {2'b01,opcode}; 0 for nop
reg1_o / reg2_o  out  DATA_W  resolved operands
wd_o  out  5  destination register
wreg_o  out  1  writes register
pc_o  out  PC_W  pc of held instruction
inst_err_o  out  1  held instruction was undecodable

Behaviour:
- Reset (async): out_valid, alusel_o, aluop_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o, inst_err_o = 0.
- Decode:
  - SPECIAL (op 0) funct AND 24h/OR 25h/XOR 26h/NOR 27h -> logic; ADDU 21h, SUBU 23h, SLT 2Ah -> arith; wd = rd; reads rs, rt.
  - SLL 00h, SRL 02h, SRA 03h -> shift; reg1 = zero-ext sa[10:6]; reads rt only; wd = rd.
  - ANDI 0Ch, ORI 0Dh, XORI 0Eh -> logic, zero-ext imm; LUI 0Fh -> logic, reg1 = 0, reg2 = {imm,16'b0} (zero-ext above bit 31).
  - ADDIU 09h, SLTI 0Ah -> arith, sign-ext imm to DATA_W. I-type: reads rs only, reg2 = imm, wd = rt.
  - Destination 0 -> wreg_o = 0.
  - Anything else -> nop: alusel/aluop/wreg = 0, inst_err_o = 1, still passes through.
- Operand resolve (per read port): addr 0 -> 0; else EX match (ex_wreg_i & ex_wd_i == addr) -> ex_wdata_i; else MEM match -> mem_wdata_i; else regfile. EX has priority over MEM. Unread ports carry the decoded constant, not register data.
- Hazard (comb): stall when a read port with nonzero addr matches an EX write and ex_is_load_i = 1. When FWD_EN = 0, any EX or MEM match also stalls.
- in_ready = !hazard & (!out_valid | out_ready).
- Pipeline register, per cycle:
  - flush_i: out_valid <= 0; no capture.
  - else in_valid & in_ready: capture decode, out_valid <= 1.
  - else if out_ready or stall-bubble: out_valid <= 0 (bubble into EX); data may hold.
  - else (out_valid & !out_ready): hold all outputs stable.
- Latency: decode visible 1 cycle after acceptance. Throughput 1/cycle without hazards. Load-use costs exactly 1 bubble when the load advances.
- flush_i has priority over capture and over hold. in_ready is not gated by flush.
- Reset mid-stall: all state cleared immediately; no instruction replayed.

Test Plan:
- Reset release, in_valid=1, ORI $2,$1,0x8001, reg1_data_i=0x10 -> next cycle out_valid=1, alusel=1, aluop=0x4D, reg1_o=0x10, reg2_o=0x00008001, wd=2, wreg=1.
- ADDIU $3,$0,0xFFFF, DATA_W=32 -> reg2_o=0xFFFFFFFF, reg1_o=0 regardless of reg1_data_i=0x55.
- ADDU $4,$5,$6 with ex_wd=5 (data 0xA), mem_wd=5 (0xB), mem_wd=6 (0xC) -> reg1_o=0xA, reg2_o=0xC. Rerun with FWD_EN=0 -> in_ready=0 until EX/MEM clear.
- EX is load to $7, ex_is_load_i=1, decode OR $8,$7,$9 -> in_ready=0 one cycle, bubble out_valid=0. Next cycle (load now in MEM) accepted with mem_wdata_i forwarded.
- out_ready=0 for 3 cycles with out_valid=1 -> all outputs stable, in_ready=0. Then flush_i=1 -> out_valid=0 next cycle. Then opcode 3Fh -> inst_err_o=1, wreg_o=0.

Source files
------------

// File: rtl/id_stage_pipe.sv
// MIPS integer-ALU instruction decode stage with EX/MEM operand forwarding,
// load-use hazard detection and a valid/ready ID/EX pipeline register.
module id_stage_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FWD_EN = 1,
    parameter int unsigned PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [31:0]       inst_i,
    output logic [4:0]        reg1_addr_o,
    output logic [4:0]        reg2_addr_o,
    output logic              reg1_read_o,
    output logic              reg2_read_o,
    input  logic [DATA_W-1:0] reg1_data_i,
    input  logic [DATA_W-1:0] reg2_data_i,
    input  logic              ex_wreg_i,
    input  logic [4:0]        ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              ex_is_load_i,
    input  logic              mem_wreg_i,
    input  logic [4:0]        mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              flush_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        alusel_o,
    output logic [7:0]        aluop_o,
    output logic [DATA_W-1:0] reg1_o,
    output logic [DATA_W-1:0] reg2_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [PC_W-1:0]   pc_o,
    output logic              inst_err_o
);

    localparam int unsigned EXT_W  = DATA_W - 16;
    localparam bit          NO_FWD = (FWD_EN == 0);

    typedef enum logic [2:0] {
        SEL_NOP   = 3'd0,
        SEL_LOGIC = 3'd1,
        SEL_SHIFT = 3'd2,
        SEL_ARITH = 3'd3
    } alusel_t;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;

    assign op    = inst_i[31:26];
    assign rs    = inst_i[25:21];
    assign rt    = inst_i[20:16];
    assign rd    = inst_i[15:11];
    assign sa    = inst_i[10:6];
    assign funct = inst_i[5:0];
    assign imm   = inst_i[15:0];

    assign reg1_addr_o = rs;
    assign reg2_addr_o = rt;

    alusel_t           d_alusel;
    logic [7:0]        d_aluop;
    logic [4:0]        d_wd;
    logic              d_wr_en;
    logic              d_wreg;
    logic              d_err;
    logic              d_rd1;
    logic              d_rd2;
    logic [DATA_W-1:0] d_const1;
    logic [DATA_W-1:0] d_const2;

    // Instruction decode: ALU class, opcode, destination, port usage, constants
    always_comb begin
        d_alusel = SEL_NOP;
        d_aluop  = 8'h00;
        d_wd     = 5'd0;
        d_wr_en  = 1'b0;
        d_err    = 1'b0;
        d_rd1    = 1'b0;
        d_rd2    = 1'b0;
        d_const1 = '0;
        d_const2 = '0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h24, 6'h25, 6'h26, 6'h27: begin
                        d_alusel = SEL_LOGIC;
                        d_aluop  = {2'b00, funct};
                        d_wd     = rd;
                        d_wr_en  = 1'b1;
                        d_rd1    = 1'b1;
                        d_rd2    = 1'b1;
                    end
                    6'h21, 6'h23, 6'h2A: begin
                        d_alusel = SEL_ARITH;
                        d_aluop  = {2'b00, funct};
                        d_wd     = rd;
                        d_wr_en  = 1'b1;
                        d_rd1    = 1'b1;
                        d_rd2    = 1'b1;
                    end
                    6'h00, 6'h02, 6'h03: begin
                        d_alusel = SEL_SHIFT;
                        d_aluop  = {2'b00, funct};
                        d_wd     = rd;
                        d_wr_en  = 1'b1;
                        d_rd2    = 1'b1;
                        d_const1 = DATA_W'(sa);
                    end
                    default: d_err = 1'b1;
                endcase
            end
            6'h0C, 6'h0D, 6'h0E: begin
                d_alusel = SEL_LOGIC;
                d_aluop  = {2'b01, op};
                d_wd     = rt;
                d_wr_en  = 1'b1;
                d_rd1    = 1'b1;
                d_const2 = DATA_W'(imm);
            end
            6'h0F: begin
                // LUI: operand 1 is a hard zero, upper half loaded from imm
                d_alusel = SEL_LOGIC;
                d_aluop  = {2'b01, op};
                d_wd     = rt;
                d_wr_en  = 1'b1;
                d_const2 = DATA_W'({imm, 16'h0000});
            end
            6'h09, 6'h0A: begin
                d_alusel = SEL_ARITH;
                d_aluop  = {2'b01, op};
                d_wd     = rt;
                d_wr_en  = 1'b1;
                d_rd1    = 1'b1;
                d_const2 = {{EXT_W{imm[15]}}, imm};
            end
            default: d_err = 1'b1;
        endcase
    end

    assign d_wreg      = d_wr_en & (d_wd != 5'd0);
    assign reg1_read_o = d_rd1;
    assign reg2_read_o = d_rd2;

    logic ex_m1;
    logic ex_m2;
    logic mem_m1;
    logic mem_m2;
    logic hazard;
    logic [DATA_W-1:0] opnd1;
    logic [DATA_W-1:0] opnd2;

    // Producer matches only count for ports actually read with a nonzero address
    assign ex_m1  = d_rd1 & (rs != 5'd0) & ex_wreg_i  & (ex_wd_i  == rs);
    assign ex_m2  = d_rd2 & (rt != 5'd0) & ex_wreg_i  & (ex_wd_i  == rt);
    assign mem_m1 = d_rd1 & (rs != 5'd0) & mem_wreg_i & (mem_wd_i == rs);
    assign mem_m2 = d_rd2 & (rt != 5'd0) & mem_wreg_i & (mem_wd_i == rt);

    // Operand select: constant, $0, EX (youngest) then MEM forwarding, then regfile
    assign opnd1 = !d_rd1       ? d_const1 :
                   (rs == 5'd0) ? '0 :
                   ex_m1        ? ex_wdata_i :
                   mem_m1       ? mem_wdata_i : reg1_data_i;
    assign opnd2 = !d_rd2       ? d_const2 :
                   (rt == 5'd0) ? '0 :
                   ex_m2        ? ex_wdata_i :
                   mem_m2       ? mem_wdata_i : reg2_data_i;

    // Load-use always stalls; without forwarding every in-flight RAW stalls
    assign hazard = ((ex_m1 | ex_m2) & ex_is_load_i)
                  | (NO_FWD & (ex_m1 | ex_m2 | mem_m1 | mem_m2));

    assign in_ready = !hazard & (!out_valid | out_ready);

    // ID/EX register: flush beats capture, capture beats bubble, else hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            alusel_o   <= 3'd0;
            aluop_o    <= 8'h00;
            reg1_o     <= '0;
            reg2_o     <= '0;
            wd_o       <= 5'd0;
            wreg_o     <= 1'b0;
            pc_o       <= '0;
            inst_err_o <= 1'b0;
        end else if (flush_i) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid  <= 1'b1;
            alusel_o   <= d_alusel;
            aluop_o    <= d_aluop;
            reg1_o     <= opnd1;
            reg2_o     <= opnd2;
            wd_o       <= d_err ? 5'd0 : d_wd;
            wreg_o     <= d_wreg;
            pc_o       <= pc_i;
            inst_err_o <= d_err;
        end else if (!out_valid || out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe (forwarding and no-forwarding builds).
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
    logic [4:0]  ex_wd_i, mem_wd_i;
    logic [31:0] ex_wdata_i, mem_wdata_i;
    logic        flush_i, out_ready;

    logic        in_ready, out_valid, reg1_read_o, reg2_read_o, wreg_o, inst_err_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o, wd_o;
    logic [2:0]  alusel_o;
    logic [7:0]  aluop_o;
    logic [31:0] reg1_o, reg2_o, pc_o;

    logic        n_in_ready, n_out_valid, n_reg1_read, n_reg2_read, n_wreg, n_err;
    logic [4:0]  n_reg1_addr, n_reg2_addr, n_wd;
    logic [2:0]  n_alusel;
    logic [7:0]  n_aluop;
    logic [31:0] n_reg1, n_reg2, n_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.DATA_W(32), .FWD_EN(1), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .inst_i(inst_i),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
        .ex_is_load_i(ex_is_load_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .flush_i(flush_i), .out_valid(out_valid), .out_ready(out_ready),
        .alusel_o(alusel_o), .aluop_o(aluop_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o), .inst_err_o(inst_err_o)
    );

    id_stage_pipe #(.DATA_W(32), .FWD_EN(0), .PC_W(32)) dut_nf (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
        .pc_i(pc_i), .inst_i(inst_i),
        .reg1_addr_o(n_reg1_addr), .reg2_addr_o(n_reg2_addr),
        .reg1_read_o(n_reg1_read), .reg2_read_o(n_reg2_read),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
        .ex_is_load_i(ex_is_load_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .flush_i(flush_i), .out_valid(n_out_valid), .out_ready(out_ready),
        .alusel_o(n_alusel), .aluop_o(n_aluop), .reg1_o(n_reg1), .reg2_o(n_reg2),
        .wd_o(n_wd), .wreg_o(n_wreg), .pc_o(n_pc), .inst_err_o(n_err)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] r1d;
        logic [31:0] r2d;
        logic        exw;
        logic [4:0]  exd;
        logic [31:0] exdat;
        logic        mw;
        logic [4:0]  md;
        logic [31:0] mdat;
        logic [2:0]  sel;
        logic [7:0]  op;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [4:0]  wd;
        logic        wreg;
        logic        err;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; pc_i = 32'h0; inst_i = 32'h0;
        reg1_data_i = 32'h0; reg2_data_i = 32'h0;
        ex_wreg_i = 1'b0; ex_wd_i = 5'd0; ex_wdata_i = 32'h0; ex_is_load_i = 1'b0;
        mem_wreg_i = 1'b0; mem_wd_i = 5'd0; mem_wdata_i = 32'h0;
        flush_i = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        //           inst          r1d           r2d           exw exd   exdat        mw  md    mdat         sel   op     e1            e2            wd     wreg  err
        vecs[0]  = '{32'h34228001, 32'h10,       32'h0,        0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       3'd1, 8'h4D, 32'h10,       32'h00008001, 5'd2,  1'b1, 1'b0}; // ORI $2,$1,0x8001
        vecs[1]  = '{32'h2403FFFF, 32'h55,       32'h0,        0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       3'd3, 8'h49, 32'h0,        32'hFFFFFFFF, 5'd3,  1'b1, 1'b0}; // ADDIU $3,$0,-1
        vecs[2]  = '{32'h00A62021, 32'h1,        32'h2,        1, 5'd5, 32'hA,       1, 5'd6, 32'hC,       3'd3, 8'h21, 32'hA,        32'hC,        5'd4,  1'b1, 1'b0}; // ADDU EX->rs, MEM->rt
        vecs[3]  = '{32'h00A62021, 32'h1,        32'h66,       1, 5'd5, 32'hA,       1, 5'd5, 32'hB,       3'd3, 8'h21, 32'hA,        32'h66,       5'd4,  1'b1, 1'b0}; // EX beats MEM
        vecs[4]  = '{32'h3C091234, 32'h77,       32'h0,        0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       3'd1, 8'h4F, 32'h0,        32'h12340000, 5'd9,  1'b1, 1'b0}; // LUI $9
        vecs[5]  = '{32'h000B5143, 32'h99,       32'h80000000, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       3'd2, 8'h03, 32'h5,        32'h80000000, 5'd10, 1'b1, 1'b0}; // SRA $10,$11,5
        vecs[6]  = '{32'h00220027, 32'h1,        32'h2,        0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       3'd1, 8'h27, 32'h1,        32'h2,        5'd0,  1'b0, 1'b0}; // NOR to $0
        vecs[7]  = '{32'h28C58000, 32'h3,        32'h0,        0, 5'd0, 32'h0,       1, 5'd6, 32'hDD,      3'd3, 8'h4A, 32'hDD,       32'hFFFF8000, 5'd5,  1'b1, 1'b0}; // SLTI MEM fwd
        vecs[8]  = '{32'h3841F0F0, 32'h4,        32'h0,        1, 5'd2, 32'hEE,      0, 5'd0, 32'h0,       3'd1, 8'h4E, 32'hEE,       32'h0000F0F0, 5'd1,  1'b1, 1'b0}; // XORI EX fwd
        vecs[9]  = '{32'hFC070000, 32'h12,       32'h34,       0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       3'd0, 8'h00, 32'h0,        32'h0,        5'd0,  1'b0, 1'b1}; // op 3Fh
        vecs[10] = '{32'h0000003F, 32'h12,       32'h34,       0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       3'd0, 8'h00, 32'h0,        32'h0,        5'd0,  1'b0, 1'b1}; // bad funct
        vecs[11] = '{32'h00021821, 32'h31,       32'h22,       1, 5'd0, 32'h99,      0, 5'd0, 32'h0,       3'd3, 8'h21, 32'h0,        32'h22,       5'd3,  1'b1, 1'b0}; // $0 never forwarded

        idle_inputs();
        rst = 1'b1;
        #2;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst alusel", 64'(alusel_o), 64'd0);
        chk("rst aluop", 64'(aluop_o), 64'd0);
        chk("rst reg1", 64'(reg1_o), 64'd0);
        chk("rst reg2", 64'(reg2_o), 64'd0);
        chk("rst wd", 64'(wd_o), 64'd0);
        chk("rst wreg", 64'(wreg_o), 64'd0);
        chk("rst pc", 64'(pc_o), 64'd0);
        chk("rst err", 64'(inst_err_o), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back decode table
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            pc_i = 32'h100 + 32'(i) * 4;
            inst_i = vecs[i].inst;
            reg1_data_i = vecs[i].r1d; reg2_data_i = vecs[i].r2d;
            ex_wreg_i = vecs[i].exw; ex_wd_i = vecs[i].exd; ex_wdata_i = vecs[i].exdat;
            ex_is_load_i = 1'b0;
            mem_wreg_i = vecs[i].mw; mem_wd_i = vecs[i].md; mem_wdata_i = vecs[i].mdat;
            #1;
            chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d alusel", i), 64'(alusel_o), 64'(vecs[i].sel));
            chk($sformatf("v%0d aluop", i), 64'(aluop_o), 64'(vecs[i].op));
            chk($sformatf("v%0d reg1", i), 64'(reg1_o), 64'(vecs[i].e1));
            chk($sformatf("v%0d reg2", i), 64'(reg2_o), 64'(vecs[i].e2));
            chk($sformatf("v%0d wd", i), 64'(wd_o), 64'(vecs[i].wd));
            chk($sformatf("v%0d wreg", i), 64'(wreg_o), 64'(vecs[i].wreg));
            chk($sformatf("v%0d err", i), 64'(inst_err_o), 64'(vecs[i].err));
            chk($sformatf("v%0d pc", i), 64'(pc_o), 64'(32'h100 + 32'(i) * 4));
        end

        // No-forwarding build stalls on any EX or MEM RAW
        idle_inputs();
        inst_i = 32'h00A62021;
        ex_wreg_i = 1'b1; ex_wd_i = 5'd5; ex_wdata_i = 32'hA;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd6; mem_wdata_i = 32'hC;
        #1;
        chk("nofwd ex+mem ready", 64'(n_in_ready), 64'd0);
        chk("fwd ex+mem ready", 64'(in_ready), 64'd1);
        ex_wreg_i = 1'b0;
        #1;
        chk("nofwd mem ready", 64'(n_in_ready), 64'd0);
        mem_wreg_i = 1'b0;
        #1;
        chk("nofwd clear ready", 64'(n_in_ready), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Load-use: one bubble, then accepted with MEM forwarding
        in_valid = 1'b1; out_ready = 1'b1; pc_i = 32'h200;
        inst_i = 32'h00E94025;
        ex_wreg_i = 1'b1; ex_wd_i = 5'd7; ex_wdata_i = 32'hBAD; ex_is_load_i = 1'b1;
        reg1_data_i = 32'h7; reg2_data_i = 32'h9;
        #1;
        chk("lu stall ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("lu bubble valid", 64'(out_valid), 64'd0);
        ex_wreg_i = 1'b0; ex_is_load_i = 1'b0;
        mem_wreg_i = 1'b1; mem_wd_i = 5'd7; mem_wdata_i = 32'h1234;
        #1;
        chk("lu resume ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("lu valid", 64'(out_valid), 64'd1);
        chk("lu reg1", 64'(reg1_o), 64'h1234);
        chk("lu reg2", 64'(reg2_o), 64'h9);
        chk("lu wd", 64'(wd_o), 64'd8);
        chk("lu aluop", 64'(aluop_o), 64'h25);

        // Backpressure holds the ID/EX register stable
        mem_wreg_i = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; inst_i = 32'h34228001; pc_i = 32'h204;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d ready", c), 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            chk($sformatf("bp%0d valid", c), 64'(out_valid), 64'd1);
            chk($sformatf("bp%0d reg1", c), 64'(reg1_o), 64'h1234);
            chk($sformatf("bp%0d aluop", c), 64'(aluop_o), 64'h25);
            chk($sformatf("bp%0d pc", c), 64'(pc_o), 64'h200);
        end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush hold valid", 64'(out_valid), 64'd0);

        // Undecodable opcode passes through flagged
        out_ready = 1'b1; in_valid = 1'b1; inst_i = 32'hFC070000; pc_i = 32'h208;
        @(posedge clk); #1;
        chk("bad valid", 64'(out_valid), 64'd1);
        chk("bad err", 64'(inst_err_o), 64'd1);
        chk("bad wreg", 64'(wreg_o), 64'd0);
        chk("bad alusel", 64'(alusel_o), 64'd0);

        // Flush wins over a simultaneous capture; in_ready not gated by flush
        inst_i = 32'h34228001; pc_i = 32'h20C; flush_i = 1'b1;
        #1;
        chk("flush cap ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush cap valid", 64'(out_valid), 64'd0);

        // Async reset during a stall clears state immediately
        reg1_data_i = 32'h10;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        chk("pre-rst valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid rst valid", 64'(out_valid), 64'd0);
        chk("mid rst pc", 64'(pc_o), 64'd0);
        chk("mid rst reg1", 64'(reg1_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post rst valid", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
